// File: rtl/common_types_pkg.sv
// Shared widths and defaults for the instruction fetch path.
package common_types;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  localparam int unsigned FETCH_DEPTH      = 4;
  localparam addr_t       RESET_PC_DEFAULT = 16'h00A0;

  function automatic addr_t addr_add(input addr_t a, input logic [1:0] n);
    return a + addr_t'(n);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular byte queue: one push per cycle, pop of 0..3 bytes, three-byte peek at the head.
module fetch_queue
  import common_types::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  data_t                        push_data,
  input  logic [1:0]                   pop_len,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output data_t                        peek0,
  output data_t                        peek1,
  output data_t                        peek2
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  data_t         mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  // Pointer plus n modulo DEPTH; n <= 3 <= DEPTH, so one subtraction is enough.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= wrap_inc(tail_q, 2'd1);
      head_q  <= wrap_inc(head_q, pop_len);
      count_q <= count_q + CW'(push) - CW'(pop_len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && push) mem_q[tail_q] <= push_data;
  end

  assign count = count_q;
  assign peek0 = mem_q[head_q];
  assign peek1 = mem_q[wrap_inc(head_q, 2'd1)];
  assign peek2 = mem_q[wrap_inc(head_q, 2'd2)];

endmodule

// File: rtl/fetch_unit.sv
// Byte-stream instruction fetcher: credit-limited memory reads feeding a queue,
// presenting a three-byte instruction window with redirect support.
module fetch_unit
  import common_types::*;
#(
  parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = FETCH_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  output logic       mem_rd,
  output addr_t      mem_addr,
  input  data_t      mem_data,
  output logic       ir_valid,
  output data_t      ir,
  output data_t      op1,
  output data_t      op2,
  output addr_t      ir_pc,
  input  logic       take,
  input  logic [1:0] take_len,
  input  logic       redirect,
  input  addr_t      redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          inflight_q;
  addr_t         fetch_pc_q;
  addr_t         ir_pc_q;
  logic          push;
  logic          do_pop;
  logic [1:0]    pop_len;

  // Credit counts the read in flight but not a same-cycle pop, so the queue cannot overflow.
  always_comb begin
    credit_used = {1'b0, count} + (CW+1)'(inflight_q);
    mem_rd      = rst & ~halt & ~redirect & (credit_used < (CW+1)'(DEPTH));
    ir_valid    = rst & (count >= CW'(3));
    do_pop      = take & ir_valid & (take_len != 2'd0) & ~redirect;
    pop_len     = do_pop ? take_len : 2'd0;
    push        = rst & inflight_q & ~redirect;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      ir_pc_q    <= RESET_PC;
      inflight_q <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      ir_pc_q    <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_rd;
      if (mem_rd) fetch_pc_q <= fetch_pc_q + 16'd1;
      ir_pc_q <= addr_add(ir_pc_q, pop_len);
    end
  end

  assign mem_addr = fetch_pc_q;
  assign ir_pc    = ir_pc_q;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (push),
    .push_data(mem_data),
    .pop_len  (pop_len),
    .count    (count),
    .peek0    (ir),
    .peek1    (op1),
    .peek2    (op2)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized runs
// against a byte-count level reference model and a fixed memory image.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        ir_valid;
  logic [7:0]  ir;
  logic [7:0]  op1;
  logic [7:0]  op2;
  logic [15:0] ir_pc;
  logic        take;
  logic [1:0]  take_len;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic [15:0] rd_addr_q;
  int checks = 0;
  int errors = 0;

  // Reference model: bytes held, read outstanding, next fetch address, window address.
  int          m_count;
  int          m_pend;
  logic [15:0] m_fetch;
  logic [15:0] m_ir;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .halt       (halt),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .ir_valid   (ir_valid),
    .ir         (ir),
    .op1        (op1),
    .op2        (op2),
    .ir_pc      (ir_pc),
    .take       (take),
    .take_len   (take_len),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h00A0: return 8'hA2;
      16'h00A1: return 8'h05;
      16'h00A2: return 8'hE8;
      16'hFFFE: return 8'h01;
      16'hFFFF: return 8'h02;
      16'h0000: return 8'h03;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // Memory answers one cycle after the read strobe.
  always @(posedge clk) rd_addr_q <= mem_addr;
  assign mem_data = mem_byte(rd_addr_q);

  function automatic logic exp_rd();
    return rst && !halt && !redirect && (m_count + m_pend < DEPTH);
  endfunction

  function automatic logic exp_valid();
    return rst && (m_count >= 3);
  endfunction

  task automatic tick();
    logic rd;
    logic v;
    int   pl;
    if (!rst) begin
      m_count = 0;
      m_pend  = 0;
      m_fetch = 16'h00A0;
      m_ir    = 16'h00A0;
    end else if (redirect) begin
      m_count = 0;
      m_pend  = 0;
      m_fetch = redirect_pc;
      m_ir    = redirect_pc;
    end else begin
      rd = exp_rd();
      v  = exp_valid();
      pl = (take && v && take_len != 2'd0) ? int'(take_len) : 0;
      m_count = m_count + m_pend - pl;
      m_pend  = rd ? 1 : 0;
      if (rd) m_fetch = m_fetch + 16'd1;
      m_ir = m_ir + 16'(pl);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; halt = 1'b0; take = 1'b0; take_len = 2'd0;
    redirect = 1'b0; redirect_pc = 16'h0000;
    @(negedge clk);
    tick();
    tick();
    #1;
    checks++;
    if (mem_rd !== 1'b0) begin
      errors++; $display("FAIL reset_mem_rd got %b want 0", mem_rd);
    end
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ir_valid got %b want 0", ir_valid);
    end
    checks++;
    if (ir_pc !== 16'h00A0) begin
      errors++; $display("FAIL reset_ir_pc got %h want 00a0", ir_pc);
    end
    checks++;
    if (mem_addr !== 16'h00A0) begin
      errors++; $display("FAIL reset_fetch_pc got %h want 00a0", mem_addr);
    end
  endtask

  task automatic test_startup();
    rst = 1'b1; halt = 1'b0; take = 1'b0; take_len = 2'd0; redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (mem_rd !== (i < 4)) begin
        errors++; $display("FAIL startup_rd cyc %0d got %b want %b", i, mem_rd, (i < 4));
      end
      if (i < 4) begin
        checks++;
        if (mem_addr !== 16'h00A0 + 16'(i)) begin
          errors++;
          $display("FAIL startup_addr cyc %0d got %h want %h", i, mem_addr, 16'h00A0 + 16'(i));
        end
      end
      checks++;
      if (ir_valid !== (i >= 4)) begin
        errors++; $display("FAIL startup_valid cyc %0d got %b want %b", i, ir_valid, (i >= 4));
      end
      if (i == 4) begin
        checks++;
        if ({ir, op1, op2, ir_pc} !== {8'hA2, 8'h05, 8'hE8, 16'h00A0}) begin
          errors++;
          $display("FAIL startup_window got %h %h %h @%h want a2 05 e8 @00a0", ir, op1, op2, ir_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_take2();
    take = 1'b1; take_len = 2'd2;
    #1;
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 16'h00A0) begin
      errors++; $display("FAIL take2_pre got v=%b pc=%h want v=1 pc=00a0", ir_valid, ir_pc);
    end
    tick();
    take = 1'b0; take_len = 2'd0;
    #1;
    checks++;
    if (ir_pc !== 16'h00A2 || ir !== 8'hE8) begin
      errors++; $display("FAIL take2_post got pc=%h ir=%h want pc=00a2 ir=e8", ir_pc, ir);
    end
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h00A4) begin
      errors++; $display("FAIL take2_resume got rd=%b addr=%h want rd=1 addr=00a4", mem_rd, mem_addr);
    end
    tick();
  endtask

  task automatic test_redirect_inflight();
    bit found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      #1;
      if (mem_rd === 1'b1 && mem_addr === 16'h00A6) found = 1'b1;
      take = ir_valid; take_len = 2'd1;
      tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL redir_find_a6 got no read of 00a6 within 30 cycles want one");
    end
    take = 1'b0; take_len = 2'd0; redirect = 1'b1; redirect_pc = 16'h00A0;
    #1;
    checks++;
    if (mem_rd !== 1'b0) begin
      errors++; $display("FAIL redir_rd_blocked got %b want 0", mem_rd);
    end
    tick();
    redirect = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (ir_valid !== 1'b0) begin
        errors++; $display("FAIL redir_valid_low cyc %0d got %b want 0", k, ir_valid);
      end
      if (k == 1) begin
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h00A0) begin
          errors++; $display("FAIL redir_first_rd got rd=%b addr=%h want 1 00a0", mem_rd, mem_addr);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (ir_valid !== 1'b1 || ir !== 8'hA2 || ir_pc !== 16'h00A0) begin
      errors++;
      $display("FAIL redir_window got v=%b ir=%h pc=%h want 1 a2 00a0", ir_valid, ir, ir_pc);
    end
    tick();
  endtask

  task automatic test_wrap();
    take = 1'b0; take_len = 2'd0; halt = 1'b0;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k < 3) begin
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFE + 16'(k)) begin
          errors++;
          $display("FAIL wrap_rd cyc %0d got rd=%b addr=%h want 1 %h", k, mem_rd, mem_addr,
                   16'hFFFE + 16'(k));
        end
      end
      if (k == 4) begin
        checks++;
        if ({ir_valid, ir, op1, op2, ir_pc} !== {1'b1, 8'h01, 8'h02, 8'h03, 16'hFFFE}) begin
          errors++;
          $display("FAIL wrap_window got v=%b %h %h %h @%h want 1 01 02 03 @fffe",
                   ir_valid, ir, op1, op2, ir_pc);
        end
      end
      tick();
    end
  endtask

  // mixed=0: take one byte every cycle with halt toggling; mixed=1: random take, length,
  // halt and occasional redirects.
  task automatic test_random(input bit mixed, input int n);
    for (int c = 0; c < n; c++) begin
      halt = ($urandom_range(0, 2) == 0);
      if (mixed) begin
        take        = ($urandom_range(0, 1) == 1);
        take_len    = 2'($urandom_range(0, 3));
        redirect    = ($urandom_range(0, 31) == 0);
        redirect_pc = 16'($urandom_range(0, 65535));
      end else begin
        take = 1'b1; take_len = 2'd1; redirect = 1'b0;
      end
      #1;
      checks++;
      if (mem_rd !== exp_rd()) begin
        errors++; $display("FAIL rand_rd cyc %0d got %b want %b", c, mem_rd, exp_rd());
      end
      if (exp_rd()) begin
        checks++;
        if (mem_addr !== m_fetch) begin
          errors++; $display("FAIL rand_addr cyc %0d got %h want %h", c, mem_addr, m_fetch);
        end
      end
      checks++;
      if (ir_valid !== exp_valid()) begin
        errors++; $display("FAIL rand_valid cyc %0d got %b want %b", c, ir_valid, exp_valid());
      end
      checks++;
      if (ir_pc !== m_ir) begin
        errors++; $display("FAIL rand_ir_pc cyc %0d got %h want %h", c, ir_pc, m_ir);
      end
      if (exp_valid()) begin
        checks++;
        if ({ir, op1, op2} !== {mem_byte(m_ir), mem_byte(m_ir + 16'd1), mem_byte(m_ir + 16'd2)})
        begin
          errors++;
          $display("FAIL rand_window cyc %0d got %h %h %h want %h %h %h", c, ir, op1, op2,
                   mem_byte(m_ir), mem_byte(m_ir + 16'd1), mem_byte(m_ir + 16'd2));
        end
      end
      if (mem_rd === 1'b1) begin
        checks++;
        if (16'(mem_addr - ir_pc) >= 16'(DEPTH)) begin
          errors++;
          $display("FAIL rand_credit cyc %0d got span %0d want < %0d", c,
                   16'(mem_addr - ir_pc), DEPTH);
        end
      end
      tick();
    end
    halt = 1'b0; take = 1'b0; take_len = 2'd0; redirect = 1'b0;
  endtask

  task automatic test_midstream_reset();
    take = 1'b0; take_len = 2'd0; halt = 1'b0; redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ir_valid !== 1'b0 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got v=%b rd=%b want 0 0", ir_valid, mem_rd);
    end
    tick();
    test_startup();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_take2();
    test_redirect_inflight();
    test_wrap();
    test_random(1'b0, 300);
    test_random(1'b1, 400);
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
